// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: ALU operand forwarding, load-use and memory-wait
// stalls, branch flushes, a sticky memory-timeout flag and stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic [1:0]  ResultSrcE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        MemErr,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
);

  localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_err_q, mem_err_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic [31:0]   flush_cnt_q, flush_cnt_d;
  logic          mem_stall_raw, mem_stall, timeout, lw_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                         input logic [4:0] rd_m, input logic wr_w,
                                         input logic [4:0] rd_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_stall_raw = 1'b0;
    timeout       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (MemReqM && !MemReadyM) begin
          mem_stall_raw = 1'b1;
          state_d       = S_WAIT;
          wait_cnt_d    = CW'(1);
        end
      end
      S_WAIT: begin
        if (MemReadyM) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == LIMIT) begin
          timeout    = 1'b1;
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else begin
          mem_stall_raw = 1'b1;
          wait_cnt_d    = wait_cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset also gates the stall combinationally so a request still presented
  // while reset is held cannot re-raise it from IDLE.
  assign mem_stall = mem_stall_raw & ~reset;

  assign StallF = lw_stall | mem_stall;
  assign StallD = lw_stall | mem_stall;
  assign StallE = mem_stall;
  assign StallM = mem_stall;
  assign FlushD = PCSrcE & ~mem_stall;
  assign FlushE = (lw_stall | PCSrcE) & ~mem_stall;
  assign FlushW = mem_stall;

  assign mem_err_d   = mem_err_q | timeout;
  assign MemErr      = mem_err_d;
  assign stall_cnt_d = (StallF && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  assign flush_cnt_d = (FlushD && flush_cnt_q != 32'hFFFF_FFFF) ? flush_cnt_q + 32'd1 : flush_cnt_q;
  assign StallCnt    = stall_cnt_q;
  assign FlushCnt    = flush_cnt_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, hand-written memory-wait
// sequences, and a randomized run against a behavioural model.
module tb_hazard_ctrl;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0]  ResultSrcE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [31:0] StallCnt, FlushCnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .ResultSrcE(ResultSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = '0;
    ResultSrcE = 2'b00;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    next_cycle();
    check("rst_stallcnt", StallCnt, 32'd0);
    check("rst_flushcnt", FlushCnt, 32'd0);
    check("rst_memerr", {31'd0, MemErr}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic check_mem(input string tag, input logic st);
    check({tag, "_stallF"}, {31'd0, StallF}, {31'd0, st});
    check({tag, "_stallD"}, {31'd0, StallD}, {31'd0, st});
    check({tag, "_stallE"}, {31'd0, StallE}, {31'd0, st});
    check({tag, "_stallM"}, {31'd0, StallM}, {31'd0, st});
    check({tag, "_flushW"}, {31'd0, FlushW}, {31'd0, st});
  endtask

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       regwm, regww, pcsrc;
    logic [1:0] rsrc;
    logic [1:0] fa, fb;
    logic       stall, flushd, flushe;
  } vec_t;

  vec_t vecs[10];

  // Behavioural model state for the randomized phase
  bit          m_wait;
  int          m_waited;
  bit          m_err;
  int unsigned m_sc, m_fc;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    reset = 1'b1;
    clear_inputs();

    //          rs1d rs2d rs1e rs2e rde rdm rdw wm ww pc rsrc  fa     fb    st fd fe
    vecs[0] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1, 1, 0, 2'b00, 2'b10, 2'b00, 0, 0, 0};
    vecs[1] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1, 1, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0};
    vecs[2] = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3, 5'd3, 0, 1, 0, 2'b00, 2'b01, 2'b01, 0, 0, 0};
    vecs[3] = '{5'd0, 5'd0, 5'd7, 5'd6, 5'd0, 5'd6, 5'd7, 1, 1, 0, 2'b00, 2'b01, 2'b10, 0, 0, 0};
    vecs[4] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0};
    vecs[5] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0, 1};
    vecs[6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0};
    vecs[7] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0, 0, 0};
    vecs[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 1, 1};
    vecs[9] = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 1, 1, 1};

    do_reset();

    // Combinational vector table, memory idle
    for (int i = 0; i < 10; i++) begin
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      RegWriteM = vecs[i].regwm; RegWriteW = vecs[i].regww; PCSrcE = vecs[i].pcsrc;
      ResultSrcE = vecs[i].rsrc;
      @(negedge clk);
      check($sformatf("v%0d_fwdA", i), {30'd0, ForwardAE}, {30'd0, vecs[i].fa});
      check($sformatf("v%0d_fwdB", i), {30'd0, ForwardBE}, {30'd0, vecs[i].fb});
      check($sformatf("v%0d_stallF", i), {31'd0, StallF}, {31'd0, vecs[i].stall});
      check($sformatf("v%0d_stallD", i), {31'd0, StallD}, {31'd0, vecs[i].stall});
      check($sformatf("v%0d_stallE", i), {31'd0, StallE}, 32'd0);
      check($sformatf("v%0d_flushD", i), {31'd0, FlushD}, {31'd0, vecs[i].flushd});
      check($sformatf("v%0d_flushE", i), {31'd0, FlushE}, {31'd0, vecs[i].flushe});
      check($sformatf("v%0d_flushW", i), {31'd0, FlushW}, 32'd0);
      next_cycle();
    end

    // Single-cycle branch flush
    do_reset();
    PCSrcE = 1'b1;
    @(negedge clk);
    check("br_flushD", {31'd0, FlushD}, 32'd1);
    check("br_flushE", {31'd0, FlushE}, 32'd1);
    next_cycle();
    PCSrcE = 1'b0;
    @(negedge clk);
    check("br_flushD_off", {31'd0, FlushD}, 32'd0);
    check("br_flushcnt", FlushCnt, 32'd1);

    // Three-cycle memory wait with a pending branch, then release
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check_mem($sformatf("mw%0d", c), 1'b1);
      check($sformatf("mw%0d_flushD", c), {31'd0, FlushD}, 32'd0);
      check($sformatf("mw%0d_flushE", c), {31'd0, FlushE}, 32'd0);
      next_cycle();
    end
    MemReadyM = 1'b1;
    @(negedge clk);
    check_mem("mw4", 1'b0);
    check("mw4_flushD", {31'd0, FlushD}, 32'd1);
    next_cycle();
    MemReqM = 1'b0; MemReadyM = 1'b0; PCSrcE = 1'b0;
    @(negedge clk);
    check("mw_stallcnt", StallCnt, 32'd3);
    check("mw_flushcnt", FlushCnt, 32'd1);

    // Timeout: request cycle plus three WAIT cycles stall, fourth WAIT cycle releases
    do_reset();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check_mem($sformatf("to%0d", c), c <= 4);
      check($sformatf("to%0d_memerr", c), {31'd0, MemErr}, {31'd0, c == 5});
      next_cycle();
    end
    for (int c = 6; c <= 7; c++) begin
      @(negedge clk);
      check_mem($sformatf("to%0d", c), 1'b1);
      check($sformatf("to%0d_memerr", c), {31'd0, MemErr}, 32'd1);
      if (c < 7) next_cycle();
    end
    check("to_stallcnt", StallCnt, 32'd5);

    // Asynchronous reset in the middle of WAIT, request still asserted
    #2;
    reset = 1'b1;
    #1;
    check_mem("ar", 1'b0);
    check("ar_stallcnt", StallCnt, 32'd0);
    check("ar_flushcnt", FlushCnt, 32'd0);
    check("ar_memerr", {31'd0, MemErr}, 32'd0);
    next_cycle();
    MemReqM = 1'b0;
    reset = 1'b0;

    // Randomized run against the behavioural model
    do_reset();
    m_wait = 0; m_waited = 0; m_err = 0; m_sc = 0; m_fc = 0;
    for (int n = 0; n < 400; n++) begin
      logic [1:0] efa, efb;
      bit lw, mem, tmo, efd, efe;
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      PCSrcE = ($urandom_range(0, 3) == 0);
      ResultSrcE = 2'($urandom_range(0, 3));
      MemReqM = ($urandom_range(0, 2) == 0);
      MemReadyM = 1'($urandom_range(0, 1));
      @(negedge clk);

      efa = ref_fwd(Rs1E);
      efb = ref_fwd(Rs2E);
      lw  = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      tmo = m_wait && !MemReadyM && m_waited == LIMIT;
      if (!m_wait) mem = MemReqM && !MemReadyM;
      else         mem = !MemReadyM && m_waited < LIMIT;
      efd = PCSrcE && !mem;
      efe = (lw || PCSrcE) && !mem;

      check("rnd_fwdA", {30'd0, ForwardAE}, {30'd0, efa});
      check("rnd_fwdB", {30'd0, ForwardBE}, {30'd0, efb});
      check("rnd_stallF", {31'd0, StallF}, {31'd0, lw || mem});
      check("rnd_stallD", {31'd0, StallD}, {31'd0, lw || mem});
      check("rnd_stallE", {31'd0, StallE}, {31'd0, mem});
      check("rnd_stallM", {31'd0, StallM}, {31'd0, mem});
      check("rnd_flushD", {31'd0, FlushD}, {31'd0, efd});
      check("rnd_flushE", {31'd0, FlushE}, {31'd0, efe});
      check("rnd_flushW", {31'd0, FlushW}, {31'd0, mem});
      check("rnd_memerr", {31'd0, MemErr}, {31'd0, m_err || tmo});
      check("rnd_stallcnt", StallCnt, m_sc);
      check("rnd_flushcnt", FlushCnt, m_fc);

      if (lw || mem) m_sc++;
      if (efd) m_fc++;
      if (tmo) m_err = 1;
      if (!m_wait) begin
        if (MemReqM && !MemReadyM) begin
          m_wait = 1;
          m_waited = 1;
        end
      end else if (MemReadyM || tmo) begin
        m_wait = 0;
      end else begin
        m_waited++;
      end
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
